// File: rtl/onehot_match_decoder_if.sv
// Branch-match stream bus: flag beats in, decoded winner and class out.
// master drives beats and out_ready; slave is the decoder.
interface onehot_match_decoder_if #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_flags;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_none;
   logic             out_multi;
   logic             out_viol;

   modport master (
      output in_valid, in_flags, mode, out_ready,
      input  in_ready, out_valid, out_idx, out_none, out_multi, out_viol
   );

   modport slave (
      input  in_valid, in_flags, mode, out_ready,
      output in_ready, out_valid, out_idx, out_none, out_multi, out_viol
   );
endinterface

// File: rtl/onehot_match_decoder.sv
// First-match branch decoder with unique/unique0 checking and saturating stats.
// Latency 1 through a single full-throughput output register; stalls on backpressure or in HALT.
module onehot_match_decoder #(
   parameter int N           = 4,
   parameter int IDX_W       = $clog2(N),
   parameter int CNT_W       = 8,
   parameter bit HALT_ON_ERR = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   onehot_match_decoder_if.slave bus,
   output logic             err_flag,
   output logic             halted,
   input  logic             err_clr,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_ok,
   output logic [CNT_W-1:0] cnt_none,
   output logic [CNT_W-1:0] cnt_multi
);
   typedef enum logic {RUN, HALT} state_t;

   state_t           state_q, state_d;
   logic             err_d;
   logic             out_valid_q;
   logic [IDX_W-1:0] out_idx_q;
   logic             out_none_q, out_multi_q, out_viol_q;

   logic             accept;
   logic             is_none, is_multi, is_viol;
   logic [IDX_W-1:0] first_idx;

   assign bus.in_ready  = (state_q == RUN) && (!out_valid_q || bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_none  = out_none_q;
   assign bus.out_multi = out_multi_q;
   assign bus.out_viol  = out_viol_q;
   assign halted        = (state_q == HALT);

   // Clearing the lowest set bit leaves something behind only if two or more were set.
   assign is_none  = ~|bus.in_flags;
   assign is_multi = |(bus.in_flags & (bus.in_flags - N'(1)));
   assign is_viol  = is_multi || (is_none && !bus.mode);

   always_comb begin
      first_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (bus.in_flags[i]) first_idx = IDX_W'(i);
      end
   end

   // Clear applies before the increment so a same-cycle beat is still counted.
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cur,
                                             input logic clr, input logic inc);
      logic [CNT_W-1:0] base;
      base = clr ? '0 : cur;
      if (inc && (base != '1)) base = base + CNT_W'(1);
      return base;
   endfunction

   always_comb begin
      state_d = state_q;
      err_d   = err_flag;
      case (state_q)
         RUN: begin
            if (accept && is_viol) begin
               err_d = 1'b1;
               if (HALT_ON_ERR) state_d = HALT;
            end else if (err_clr) begin
               err_d = 1'b0;
            end
         end
         HALT: begin
            if (err_clr) begin
               state_d = RUN;
               err_d   = 1'b0;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RUN;
         err_flag  <= 1'b0;
         cnt_ok    <= '0;
         cnt_none  <= '0;
         cnt_multi <= '0;
      end else begin
         state_q   <= state_d;
         err_flag  <= err_d;
         cnt_ok    <= bump(cnt_ok,    cnt_clr, accept && !is_none && !is_multi);
         cnt_none  <= bump(cnt_none,  cnt_clr, accept && is_none);
         cnt_multi <= bump(cnt_multi, cnt_clr, accept && is_multi);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_none_q  <= 1'b0;
         out_multi_q <= 1'b0;
         out_viol_q  <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_idx_q   <= first_idx;
         out_none_q  <= is_none;
         out_multi_q <= is_multi;
         out_viol_q  <= is_viol;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_onehot_match_decoder.sv
// Directed bench: halting 8-bit-counter instance plus a non-halting 2-bit-counter instance.
module tb_onehot_match_decoder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   onehot_match_decoder_if #(.N(4)) bus ();
   onehot_match_decoder_if #(.N(4)) bus2 ();

   logic       err_clr, cnt_clr, err_flag, halted;
   logic [7:0] cnt_ok, cnt_none, cnt_multi;
   logic       err_clr2, cnt_clr2, err_flag2, halted2;
   logic [1:0] cnt_ok2, cnt_none2, cnt_multi2;

   onehot_match_decoder #(.N(4), .CNT_W(8), .HALT_ON_ERR(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .err_flag(err_flag), .halted(halted), .err_clr(err_clr), .cnt_clr(cnt_clr),
      .cnt_ok(cnt_ok), .cnt_none(cnt_none), .cnt_multi(cnt_multi)
   );

   onehot_match_decoder #(.N(4), .CNT_W(2), .HALT_ON_ERR(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2),
      .err_flag(err_flag2), .halted(halted2), .err_clr(err_clr2), .cnt_clr(cnt_clr2),
      .cnt_ok(cnt_ok2), .cnt_none(cnt_none2), .cnt_multi(cnt_multi2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] flags;
      logic       mode;
      logic [1:0] idx;
      logic       none;
      logic       multi;
      logic       viol;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{4'b0100, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{4'b1000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{4'b0010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; err_clr = 1'b0; cnt_clr = 1'b0;
      bus.in_valid = 1'b0; bus.in_flags = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
      err_clr2 = 1'b0; cnt_clr2 = 1'b0;
      bus2.in_valid = 1'b0; bus2.in_flags = '0; bus2.mode = 1'b0; bus2.out_ready = 1'b1;
      step(); step();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_err_flag", err_flag, 0);
      chk("rst_halted", halted, 0);
      chk("rst_cnt_ok", cnt_ok, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_cnt_ok2", cnt_ok2, 0);
      rst_n = 1'b1;

      // Back-to-back legal beats, one result per cycle.
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1; bus.in_flags = vecs[i].flags; bus.mode = vecs[i].mode;
         step();
         chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
         chk($sformatf("vec%0d_idx", i), bus.out_idx, vecs[i].idx);
         chk($sformatf("vec%0d_none", i), bus.out_none, vecs[i].none);
         chk($sformatf("vec%0d_multi", i), bus.out_multi, vecs[i].multi);
         chk($sformatf("vec%0d_viol", i), bus.out_viol, vecs[i].viol);
         chk($sformatf("vec%0d_err", i), err_flag, 0);
      end
      bus.in_valid = 1'b0;
      step();
      chk("drain_valid", bus.out_valid, 0);
      chk("tbl_cnt_ok", cnt_ok, 4);
      chk("tbl_cnt_none", cnt_none, 1);

      // Zero flags in unique mode halts; further beats are refused.
      bus.in_valid = 1'b1; bus.in_flags = 4'b0000; bus.mode = 1'b0;
      step();
      chk("none_viol", bus.out_viol, 1);
      chk("none_none", bus.out_none, 1);
      chk("none_err", err_flag, 1);
      chk("none_halted", halted, 1);
      chk("none_in_ready", bus.in_ready, 0);
      chk("none_cnt_none", cnt_none, 2);
      bus.in_flags = 4'b0001;
      step(); step();
      chk("halt_drained", bus.out_valid, 0);
      chk("halt_no_accept", cnt_ok, 4);
      bus.in_valid = 1'b0; err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr1_halted", halted, 0);
      chk("clr1_err", err_flag, 0);
      chk("clr1_in_ready", bus.in_ready, 1);

      // Multi-match violates even in unique0 mode.
      bus.in_valid = 1'b1; bus.in_flags = 4'b0110; bus.mode = 1'b1;
      step();
      chk("multi_idx", bus.out_idx, 1);
      chk("multi_multi", bus.out_multi, 1);
      chk("multi_viol", bus.out_viol, 1);
      chk("multi_halted", halted, 1);
      chk("multi_cnt", cnt_multi, 1);
      bus.in_valid = 1'b0; err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr2_halted", halted, 0);
      chk("clr2_err", err_flag, 0);
      chk("clr2_in_ready", bus.in_ready, 1);

      // Backpressure: result held, next beat waits, nothing lost or duplicated.
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_flags = 4'b0010; bus.mode = 1'b0;
      step();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_idx", bus.out_idx, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      bus.in_flags = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("bp_hold%0d_idx", i), bus.out_idx, 1);
         chk($sformatf("bp_hold%0d_rdy", i), bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", bus.in_ready, 1);
      step();
      chk("bp_next_valid", bus.out_valid, 1);
      chk("bp_next_idx", bus.out_idx, 2);
      bus.in_valid = 1'b0;
      step();
      chk("bp_end_valid", bus.out_valid, 0);
      chk("bp_cnt_ok", cnt_ok, 6);

      // Clear with a same-cycle legal beat counts that beat.
      bus.in_valid = 1'b1; bus.in_flags = 4'b0001; cnt_clr = 1'b1;
      step();
      bus.in_valid = 1'b0; cnt_clr = 1'b0;
      chk("clr_cnt_ok", cnt_ok, 1);
      chk("clr_cnt_none", cnt_none, 0);
      chk("clr_cnt_multi", cnt_multi, 0);

      // Narrow counters saturate; no halting in this instance.
      bus2.in_valid = 1'b1; bus2.in_flags = 4'b0001; bus2.mode = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("sat_cnt_ok2", cnt_ok2, 3);
      cnt_clr2 = 1'b1;
      step();
      cnt_clr2 = 1'b0;
      chk("sat_clr_cnt_ok2", cnt_ok2, 1);
      bus2.in_flags = 4'b0011;
      step();
      chk("nh_err2", err_flag2, 1);
      chk("nh_halted2", halted2, 0);
      chk("nh_in_ready2", bus2.in_ready, 1);
      err_clr2 = 1'b1;
      step();
      chk("nh_set_wins", err_flag2, 1);
      bus2.in_valid = 1'b0;
      step();
      err_clr2 = 1'b0;
      chk("nh_clr_err2", err_flag2, 0);

      // Reset while a violating result is held and the block is halted.
      bus.in_valid = 1'b1; bus.in_flags = 4'b0011; bus.mode = 1'b0;
      step();
      chk("pre_rst_halted", halted, 1);
      chk("pre_rst_valid", bus.out_valid, 1);
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; rst_n = 1'b0;
      step();
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_halted", halted, 0);
      chk("mid_rst_err", err_flag, 0);
      chk("mid_rst_idx", bus.out_idx, 0);
      chk("mid_rst_multi", bus.out_multi, 0);
      chk("mid_rst_viol", bus.out_viol, 0);
      chk("mid_rst_cnt_multi", cnt_multi, 0);
      chk("mid_rst_cnt_ok", cnt_ok, 0);
      chk("mid_rst_in_ready", bus.in_ready, 1);
      rst_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
